// File: rtl/xor_frame_parity_checker_if.sv
// xor_frame_parity_checker_if: beat input and frame result bundle for the parity checker
interface xor_frame_parity_checker_if #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] I;
    logic             VALID;
    logic             START;
    logic [WIDTH-1:0] O;
    logic             DONE;
    logic             ERR;
    logic             BUSY;
    logic [CNT_W-1:0] FRAMES;
    logic [CNT_W-1:0] ERRS;
    modport master (output I, VALID, START, input O, DONE, ERR, BUSY, FRAMES, ERRS);
    modport slave  (input I, VALID, START, output O, DONE, ERR, BUSY, FRAMES, ERRS);
endinterface

// File: rtl/xor_frame_parity_checker.sv
// xor_frame_parity_checker: XOR-accumulates FRAME_LEN beats and checks them against a trailing checksum beat
module xor_frame_parity_checker #(
    parameter int WIDTH     = 2,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 8
) (
    input logic                   CLK,
    input logic                   RESET,
    xor_frame_parity_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, CHECK} state_t;
    localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);
    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [7:0]       cnt;
    assign bus.BUSY = state != IDLE;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            bus.O      <= '0;
            bus.DONE   <= 1'b0;
            bus.ERR    <= 1'b0;
            bus.FRAMES <= '0;
            bus.ERRS   <= '0;
        end else begin
            bus.DONE <= 1'b0;
            // START begins a frame from IDLE and aborts one in progress; its beat is never consumed
            if (bus.START) begin
                state <= ACCUM;
                acc   <= '0;
                cnt   <= '0;
            end else begin
                case (state)
                    ACCUM: if (bus.VALID) begin
                        acc <= acc ^ bus.I;
                        if (cnt == LAST) state <= CHECK;
                        else cnt <= cnt + 8'd1;
                    end
                    CHECK: if (bus.VALID) begin
                        state      <= IDLE;
                        bus.O      <= acc;
                        bus.ERR    <= bus.I != acc;
                        bus.DONE   <= 1'b1;
                        bus.FRAMES <= (&bus.FRAMES) ? bus.FRAMES : bus.FRAMES + 1'b1;
                        if (bus.I != acc && !(&bus.ERRS)) bus.ERRS <= bus.ERRS + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_xor_frame_parity_checker.sv
// tb_xor_frame_parity_checker: directed frames with a scoreboard queue popped by a DONE monitor
module tb_xor_frame_parity_checker;
    typedef struct packed {
        logic [1:0] o;
        logic       err;
        logic [7:0] frames;
        logic [7:0] errs;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    xor_frame_parity_checker_if #(.WIDTH(2), .CNT_W(8)) bus ();
    xor_frame_parity_checker #(.WIDTH(2), .FRAME_LEN(4), .CNT_W(8)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus.slave)
    );

    always #5 CLK = ~CLK;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   m_frames = 0;
    int   m_errs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every DONE pulse must match the oldest queued expectation
    always @(negedge CLK) begin
        if (bus.DONE === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_o", 32'(bus.O), 32'(e.o));
                check("sb_err", 32'(bus.ERR), 32'(e.err));
                check("sb_frames", 32'(bus.FRAMES), 32'(e.frames));
                check("sb_errs", 32'(bus.ERRS), 32'(e.errs));
                check("sb_busy", 32'(bus.BUSY), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start();
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
    endtask

    task automatic beat(input logic [1:0] d);
        bus.VALID = 1'b1;
        bus.I = d;
        tick();
        bus.VALID = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            check("busy_gap", 32'(bus.BUSY), 32'd1);
        end
    endtask

    task automatic send_chk(input logic [1:0] cs, input logic [1:0] exp_o);
        exp_t e;
        m_frames = (m_frames == 255) ? 255 : m_frames + 1;
        if (cs != exp_o) m_errs = (m_errs == 255) ? 255 : m_errs + 1;
        e.o = exp_o;
        e.err = cs != exp_o;
        e.frames = 8'(m_frames);
        e.errs = 8'(m_errs);
        q.push_back(e);
        beat(cs);
        check("done_latency", 32'(bus.DONE), 32'd1);
    endtask

    task automatic frame(input logic [1:0] b0, b1, b2, b3, cs, exp_o, input int g);
        start();
        beat(b0); gap(g);
        beat(b1); gap(g);
        beat(b2); gap(g);
        beat(b3); gap(g);
        send_chk(cs, exp_o);
    endtask

    initial begin
        bus.I = 2'b00;
        bus.VALID = 1'b0;
        bus.START = 1'b0;
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        check("rst_o", 32'(bus.O), 32'd0);
        check("rst_done", 32'(bus.DONE), 32'd0);
        check("rst_err", 32'(bus.ERR), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_frames", 32'(bus.FRAMES), 32'd0);
        check("rst_errs", 32'(bus.ERRS), 32'd0);

        // basic passing frame: 01^10^11^00 = 00
        frame(2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 0);
        tick();
        check("done_one_cycle", 32'(bus.DONE), 32'd0);
        check("busy_after", 32'(bus.BUSY), 32'd0);

        // mismatch: 01^01^01^10 = 11 vs checksum 10, then a passing frame
        frame(2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 0);
        frame(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 0);
        tick();
        check("err_cleared", 32'(bus.ERR), 32'd0);
        check("errs_held", 32'(bus.ERRS), 32'd1);

        // gaps of 3 idle cycles between every beat
        frame(2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 3);
        tick();

        // abort: START with VALID=1 discards the 01 beat
        start();
        beat(2'b11);
        beat(2'b11);
        bus.VALID = 1'b1;
        bus.I = 2'b01;
        start();
        bus.VALID = 1'b0;
        check("abort_done", 32'(bus.DONE), 32'd0);
        check("abort_frames", 32'(bus.FRAMES), 32'd4);
        check("abort_o", 32'(bus.O), 32'd0);
        check("abort_busy", 32'(bus.BUSY), 32'd1);
        beat(2'b10);
        beat(2'b00);
        beat(2'b00);
        beat(2'b00);
        send_chk(2'b10, 2'b10);
        tick();

        // reset while waiting for the checksum
        start();
        beat(2'b01);
        beat(2'b01);
        beat(2'b10);
        beat(2'b11);
        check("check_busy", 32'(bus.BUSY), 32'd1);
        RESET = 1'b1;
        bus.VALID = 1'b1;
        bus.I = 2'b11;
        tick();
        RESET = 1'b0;
        bus.VALID = 1'b0;
        m_frames = 0;
        m_errs = 0;
        check("rst_chk_busy", 32'(bus.BUSY), 32'd0);
        check("rst_chk_done", 32'(bus.DONE), 32'd0);
        check("rst_chk_frames", 32'(bus.FRAMES), 32'd0);
        check("rst_chk_errs", 32'(bus.ERRS), 32'd0);
        check("rst_chk_o", 32'(bus.O), 32'd0);
        tick();
        check("rst_chk_nodone", 32'(bus.DONE), 32'd0);

        // 260 back-to-back frames, frames 10 and 200 mismatched
        for (int f = 0; f < 260; f++) begin
            logic [1:0] b0, b1, b2, b3, a;
            b0 = 2'(f);
            b1 = 2'(f >> 2);
            b2 = 2'(f >> 4);
            b3 = 2'b10;
            a = b0 ^ b1 ^ b2 ^ b3;
            frame(b0, b1, b2, b3, (f == 10 || f == 200) ? a ^ 2'b01 : a, a, 0);
        end
        tick();
        check("sat_frames", 32'(bus.FRAMES), 32'd255);
        check("sat_errs", 32'(bus.ERRS), 32'd2);

        for (int k = 0; k < 10 && q.size() != 0; k++) tick();
        check("sb_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
